// File: rtl/cordic_nco_driver_if.sv
// Handshake bundle between the NCO driver, the CORDIC core and the downstream sample consumer.
// master = driver side, slave = CORDIC / consumer side.
interface cordic_nco_driver_if #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned ANGLE_WIDTH = 32
);
  logic                   cordic_start;
  logic [ANGLE_WIDTH-1:0] cordic_angle;
  logic [WIDTH-1:0]       cordic_x_start;
  logic [WIDTH-1:0]       cordic_y_start;
  logic [WIDTH-1:0]       cordic_cos;
  logic [WIDTH-1:0]       cordic_sin;
  logic                   cordic_done;
  logic [WIDTH-1:0]       sample_cos;
  logic [WIDTH-1:0]       sample_sin;
  logic                   sample_valid;
  logic                   sample_ready;

  modport master (
    output cordic_start, cordic_angle, cordic_x_start, cordic_y_start,
    output sample_cos, sample_sin, sample_valid,
    input  cordic_cos, cordic_sin, cordic_done, sample_ready
  );

  modport slave (
    input  cordic_start, cordic_angle, cordic_x_start, cordic_y_start,
    input  sample_cos, sample_sin, sample_valid,
    output cordic_cos, cordic_sin, cordic_done, sample_ready
  );
endinterface

// File: rtl/cordic_nco_driver.sv
// Phase-accumulating NCO front end for an iterative CORDIC: issues one angle per sample,
// captures the rotated result and delivers it downstream over a valid/ready handshake.
module cordic_nco_driver #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned ANGLE_WIDTH = 32,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          phase_load,
  input  logic signed [ANGLE_WIDTH-1:0] phase_init,
  input  logic signed [ANGLE_WIDTH-1:0] phase_inc,
  output logic [15:0]                   sample_count,
  output logic                          timeout_err,
  cordic_nco_driver_if.master           bus
);

  typedef logic signed [ANGLE_WIDTH:0] sum_t;
  typedef enum logic [1:0] {StIdle, StIssue, StWait, StHold} state_e;

  localparam sum_t Pi    = sum_t'(33'sh06487ED51);
  localparam sum_t TwoPi = sum_t'(33'sh0C90FDAA2);

  // The start cycle counts toward the budget, so the last WAIT cycle sees TIMEOUT-2.
  localparam int unsigned WdogW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WdogW-1:0] WdogLast = WdogW'(TIMEOUT - 2);

  state_e                        state;
  logic signed [ANGLE_WIDTH-1:0] phase_acc;
  logic [WdogW-1:0]              wdog;
  sum_t                          phase_sum;
  sum_t                          phase_wrapped;

  assign bus.cordic_x_start = WIDTH'(16'h26DD);
  assign bus.cordic_y_start = '0;

  // Keep the accumulator in [-PI, PI) with a single conditional wrap.
  always_comb begin
    phase_sum     = sum_t'(phase_acc) + sum_t'(phase_inc);
    phase_wrapped = phase_sum;
    if (phase_sum >= Pi) begin
      phase_wrapped = phase_sum - TwoPi;
    end else if (phase_sum < -Pi) begin
      phase_wrapped = phase_sum + TwoPi;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= StIdle;
      phase_acc        <= '0;
      wdog             <= '0;
      bus.cordic_start <= 1'b0;
      bus.cordic_angle <= '0;
      bus.sample_cos   <= '0;
      bus.sample_sin   <= '0;
      bus.sample_valid <= 1'b0;
      sample_count     <= '0;
      timeout_err      <= 1'b0;
    end else begin
      bus.cordic_start <= 1'b0;
      case (state)
        StIdle: begin
          if (phase_load) begin
            phase_acc <= phase_init;
          end else if (enable) begin
            state            <= StIssue;
            bus.cordic_start <= 1'b1;
            bus.cordic_angle <= phase_acc;
          end
        end
        StIssue: begin
          phase_acc <= phase_wrapped[ANGLE_WIDTH-1:0];
          wdog      <= '0;
          state     <= StWait;
        end
        StWait: begin
          if (bus.cordic_done) begin
            bus.sample_cos   <= bus.cordic_cos;
            bus.sample_sin   <= bus.cordic_sin;
            bus.sample_valid <= 1'b1;
            state            <= StHold;
          end else if (wdog == WdogLast) begin
            timeout_err <= 1'b1;
            state       <= StIdle;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        StHold: begin
          if (bus.sample_ready) begin
            bus.sample_valid <= 1'b0;
            sample_count     <= sample_count + 16'd1;
            if (enable) begin
              state            <= StIssue;
              bus.cordic_start <= 1'b1;
              bus.cordic_angle <= phase_acc;
            end else begin
              state <= StIdle;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_nco_driver.sv
// Bench for cordic_nco_driver: a transaction-level model checked every cycle, a behavioural
// CORDIC peripheral, and directed scenarios with hand-computed literal expectations.
module tb_cordic_nco_driver;
  localparam int TIMEOUT = 64;
  localparam longint PiL = 64'sh6487ED51;
  localparam longint HalfPiL = 64'sh3243F6A9;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        phase_load = 1'b0;
  logic [31:0] phase_init = '0;
  logic [31:0] phase_inc = '0;
  logic [15:0] sample_count;
  logic        timeout_err;

  cordic_nco_driver_if #(.WIDTH(16), .ANGLE_WIDTH(32)) bus ();

  cordic_nco_driver #(.WIDTH(16), .ANGLE_WIDTH(32), .TIMEOUT(TIMEOUT)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .phase_load  (phase_load),
    .phase_init  (phase_init),
    .phase_inc   (phase_inc),
    .sample_count(sample_count),
    .timeout_err (timeout_err),
    .bus         (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_starts = 0;
  int err_cyc = 0;
  bit err_seen = 0;
  logic [31:0] angle_log[$];
  int start_cyc[$];
  longint atan_tab[15];

  // Model state
  logic [31:0] exp_phase = '0;
  logic [31:0] last_angle = '0;
  logic [15:0] exp_cos = '0, exp_sin = '0, exp_count = '0;
  bit exp_valid = 0, exp_err = 0, armed = 0, prev_start = 0;
  int since = 0;

  // CORDIC peripheral controls
  int cd_lat = 4;
  bit cd_never = 0;
  bit cd_inject = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] nco_step(input logic [31:0] p, input logic [31:0] d);
    longint s;
    s = longint'(signed'(p)) + longint'(signed'(d));
    if (s >= PiL) s = s - 2 * PiL;
    else if (s < -PiL) s = s + 2 * PiL;
    return s[31:0];
  endfunction

  function automatic void cordic_calc(input logic [31:0] ang, output logic [15:0] c,
                                      output logic [15:0] s);
    longint x, y, z, xn;
    x = 64'sd9949;
    y = 0;
    z = longint'(signed'(ang));
    if (z > HalfPiL) begin
      xn = -y; y = x; x = xn; z = z - HalfPiL;
    end else if (z < -HalfPiL) begin
      xn = y; y = -x; x = xn; z = z + HalfPiL;
    end
    for (int i = 0; i < 15; i++) begin
      if (z >= 0) begin
        xn = x - (y >>> i); y = y + (x >>> i); x = xn; z = z - atan_tab[i];
      end else begin
        xn = x + (y >>> i); y = y - (x >>> i); x = xn; z = z + atan_tab[i];
      end
    end
    c = x[15:0];
    s = y[15:0];
  endfunction

  // Behavioural CORDIC: result appears cd_lat cycles after the start pulse.
  initial begin : cordic_model
    int cnt;
    bit busy;
    logic [15:0] rc, rs;
    busy = 0; cnt = 0; rc = '0; rs = '0;
    bus.cordic_done = 1'b0;
    bus.cordic_cos = '0;
    bus.cordic_sin = '0;
    for (int i = 0; i < 15; i++) atan_tab[i] = longint'($rtoi($atan(1.0 / (2.0 ** i)) * 536870912.0));
    forever begin
      @(negedge clock);
      if (bus.cordic_start === 1'b1) begin
        busy = !cd_never;
        cnt = (cd_lat < 1) ? 1 : cd_lat;
        cordic_calc(bus.cordic_angle, rc, rs);
      end
      @(posedge clock);
      #1;
      bus.cordic_done = cd_inject;
      if (busy) begin
        cnt--;
        if (cnt == 0) begin
          bus.cordic_done = 1'b1;
          bus.cordic_cos = rc;
          bus.cordic_sin = rs;
          busy = 0;
        end
      end
    end
  end

  // Single compare process: outputs against the transaction model on every cycle.
  initial begin : compare
    forever begin
      @(negedge clock);
      cyc++;
      check("x_start", bus.cordic_x_start, 16'h26DD);
      check("y_start", bus.cordic_y_start, 16'h0000);
      check("sample_valid", bus.sample_valid, exp_valid);
      check("sample_cos", bus.sample_cos, exp_cos);
      check("sample_sin", bus.sample_sin, exp_sin);
      check("sample_count", sample_count, exp_count);
      check("timeout_err", timeout_err, exp_err);
      if (timeout_err === 1'b1 && !err_seen) begin
        err_seen = 1;
        err_cyc = cyc;
      end
      if (exp_valid && bus.sample_ready === 1'b1) begin
        exp_valid = 0;
        exp_count = exp_count + 16'd1;
      end
      if (bus.cordic_start === 1'b1) begin
        check("start_angle", bus.cordic_angle, exp_phase);
        check("start_while_busy", {prev_start, exp_valid, armed}, 3'b000);
        angle_log.push_back(bus.cordic_angle);
        start_cyc.push_back(cyc);
        n_starts++;
        last_angle = bus.cordic_angle;
        exp_phase = nco_step(exp_phase, phase_inc);
        armed = 1;
        since = 0;
      end else begin
        check("angle_hold", bus.cordic_angle, last_angle);
        if (armed) begin
          since++;
          if (bus.cordic_done === 1'b1) begin
            armed = 0;
            exp_valid = 1;
            exp_cos = bus.cordic_cos;
            exp_sin = bus.cordic_sin;
          end else if (since == TIMEOUT - 1) begin
            armed = 0;
            exp_err = 1;
          end
        end
      end
      prev_start = bus.cordic_start;
      if (reset === 1'b1) begin
        exp_phase = '0; last_angle = '0; exp_cos = '0; exp_sin = '0; exp_count = '0;
        exp_valid = 0; exp_err = 0; armed = 0; prev_start = 0; err_seen = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic load_phase(input logic [31:0] p);
    phase_init = p;
    phase_load = 1'b1;
    exp_phase = p;
    tick(1);
    phase_load = 1'b0;
  endtask

  task automatic wait_starts(input int target, input int budget);
    int k;
    k = 0;
    while (n_starts < target && k < budget) begin
      tick(1);
      k++;
    end
    check("wait_start", n_starts, target);
  endtask

  task automatic wait_valid(input int budget);
    int k;
    k = 0;
    while (bus.sample_valid !== 1'b1 && k < budget) begin
      tick(1);
      k++;
    end
    check("wait_valid", bus.sample_valid, 1'b1);
  endtask

  initial begin : stimulus
    int n0, k, cv, sv;
    logic [15:0] rc, rs;
    bus.sample_ready = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);
    check("rst_angle", bus.cordic_angle, 32'h0);
    check("rst_start", bus.cordic_start, 1'b0);

    // Positive wrap, throughput L+2, enable drop completes the in-flight sample
    cd_lat = 4;
    phase_inc = 32'h3243F6A9;
    load_phase(32'h0);
    n0 = n_starts;
    enable = 1'b1;
    wait_starts(n0 + 3, 60);
    enable = 1'b0;
    tick(20);
    check("wrap_a0", angle_log[n0], 32'h00000000);
    check("wrap_a1", angle_log[n0+1], 32'h3243F6A9);
    check("wrap_a2", angle_log[n0+2], 32'h9B7812B0);
    check("throughput", start_cyc[n0+1] - start_cyc[n0], 6);
    check("wrap_count", sample_count, 16'd3);

    // Negative wrap
    phase_inc = 32'hCDBC0957;
    load_phase(32'h9B7812B0);
    n0 = n_starts;
    enable = 1'b1;
    wait_starts(n0 + 2, 40);
    enable = 1'b0;
    tick(20);
    check("nwrap_a0", angle_log[n0], 32'h9B7812B0);
    check("nwrap_a1", angle_log[n0+1], 32'h3243F6A9);

    // phase_load outside IDLE and cordic_done outside WAIT are ignored
    cd_lat = 8;
    phase_inc = 32'h01000000;
    load_phase(32'h10000000);
    n0 = n_starts;
    enable = 1'b1;
    wait_starts(n0 + 1, 20);
    phase_init = 32'h70000000;
    phase_load = 1'b1;
    tick(2);
    phase_load = 1'b0;
    wait_starts(n0 + 2, 40);
    enable = 1'b0;
    tick(20);
    check("load_ignored", angle_log[n0+1], 32'h11000000);
    cd_inject = 1'b1;
    tick(2);
    cd_inject = 1'b0;
    tick(4);
    check("done_ignored_valid", bus.sample_valid, 1'b0);
    check("done_ignored_count", sample_count, 16'd7);

    // Done in the last permitted cycle beats the watchdog
    cd_lat = TIMEOUT - 1;
    n0 = n_starts;
    enable = 1'b1;
    wait_starts(n0 + 1, 20);
    enable = 1'b0;
    tick(TIMEOUT + 10);
    check("late_done_err", timeout_err, 1'b0);
    check("late_done_count", sample_count, 16'd8);

    // Backpressure
    do_reset();
    cd_lat = 3;
    phase_inc = 32'h00100000;
    load_phase(32'h01000000);
    n0 = n_starts;
    bus.sample_ready = 1'b0;
    enable = 1'b1;
    wait_valid(30);
    tick(10);
    cordic_calc(32'h01000000, rc, rs);
    check("bp_valid", bus.sample_valid, 1'b1);
    check("bp_cos", bus.sample_cos, rc);
    check("bp_sin", bus.sample_sin, rs);
    check("bp_no_start", n_starts, n0 + 1);
    check("bp_count", sample_count, 16'd0);
    bus.sample_ready = 1'b1;
    enable = 1'b0;
    tick(2);
    check("bp_count_after", sample_count, 16'd1);
    check("bp_valid_after", bus.sample_valid, 1'b0);

    // Timeout
    do_reset();
    cd_never = 1;
    n0 = n_starts;
    enable = 1'b1;
    wait_starts(n0 + 1, 20);
    enable = 1'b0;
    k = 0;
    while (!err_seen && k < TIMEOUT + 20) begin
      tick(1);
      k++;
    end
    check("to_seen", err_seen, 1'b1);
    check("to_latency", err_cyc - start_cyc[n0], TIMEOUT);
    check("to_valid", bus.sample_valid, 1'b0);
    cd_never = 0;
    cd_lat = 4;
    enable = 1'b1;
    wait_starts(n0 + 2, 20);
    enable = 1'b0;
    tick(15);
    check("to_sticky", timeout_err, 1'b1);

    // Reset during WAIT, then the CORDIC completes
    do_reset();
    cd_lat = 6;
    phase_inc = 32'h05000000;
    load_phase(32'h20000000);
    n0 = n_starts;
    enable = 1'b1;
    wait_starts(n0 + 1, 20);
    enable = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(12);
    check("rw_valid", bus.sample_valid, 1'b0);
    check("rw_count", sample_count, 16'd0);
    check("rw_angle", bus.cordic_angle, 32'h0);
    check("rw_cos", bus.sample_cos, 16'h0);
    check("rw_err", timeout_err, 1'b0);

    // End to end with the 15-iteration CORDIC, angle 0
    do_reset();
    cd_lat = 15;
    phase_inc = 32'h0;
    load_phase(32'h0);
    n0 = n_starts;
    enable = 1'b1;
    wait_starts(n0 + 1, 20);
    enable = 1'b0;
    wait_valid(30);
    tick(2);
    cv = int'($signed(bus.sample_cos));
    sv = int'($signed(bus.sample_sin));
    check("e2e_cos", cv, 32'(cv >= 16380 && cv <= 16388 ? cv : 16384));
    check("e2e_sin", sv, 32'(sv >= -4 && sv <= 4 ? sv : 0));
    check("e2e_count", sample_count, 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : global_bound
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got cycle %0d, required finish", cyc);
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/cordic_nco_driver.md
CORDIC_NCO_DRIVER -- requirements
Module: cordic_nco_driver

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, which sets the sample and coordinate width.
REQ-002 The block SHALL have parameter ANGLE_WIDTH, default 32, which sets the angle width (signed, radians, 29 fractional bits; PI = 32'h6487ED51).
REQ-003 The block SHALL have parameter TIMEOUT, default 64, which sets the maximum number of cycles to wait for cordic_done.
REQ-004 The block SHALL have port clock, input, width 1, the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port reset, input, width 1; reset is synchronous and active-high.
REQ-006 The block SHALL have port enable, input, width 1, which allows new samples to be issued while high.
REQ-007 The block SHALL have port phase_load, input, width 1, which loads phase_init into the accumulator (honoured in IDLE only).
REQ-008 The block SHALL have port phase_init, input, width ANGLE_WIDTH, the signed initial phase.
REQ-009 The block SHALL have port phase_inc, input, width ANGLE_WIDTH, the signed per-sample increment, with |phase_inc| <= PI.
REQ-010 The block SHALL have port cordic_start, output, width 1, a one-cycle start pulse to the CORDIC.
REQ-011 The block SHALL have port cordic_angle, output, width ANGLE_WIDTH, the angle presented to the CORDIC.
REQ-012 The block SHALL have port cordic_x_start, output, width WIDTH, held constant at 16'h26DD (gain compensation).
REQ-013 The block SHALL have port cordic_y_start, output, width WIDTH, held constant at 0.
REQ-014 The block SHALL have ports cordic_cos and cordic_sin, input, width WIDTH each, the CORDIC results.
REQ-015 The block SHALL have port cordic_done, input, width 1, the CORDIC completion pulse.
REQ-016 The block SHALL have ports sample_cos and sample_sin, output, width WIDTH each, the captured sample.
REQ-017 The block SHALL have ports sample_valid (output, width 1) and sample_ready (input, width 1), a valid/ready handshake to downstream.
REQ-018 The block SHALL have port sample_count, output, width 16, counting delivered samples and wrapping from 0xFFFF to 0.
REQ-019 The block SHALL have port timeout_err, output, width 1, a sticky flag set when a CORDIC timeout occurs.

Function
REQ-020 The block SHALL implement the states IDLE, ISSUE, WAIT and HOLD.
REQ-021 In IDLE, phase_load SHALL take priority: phase_acc <= phase_init and no issue occurs that cycle; otherwise, if enable=1, the block SHALL go to ISSUE.
REQ-022 In ISSUE, the block SHALL assert cordic_start for exactly one cycle with cordic_angle = phase_acc, update phase_acc (REQ-026), clear the watchdog, and go to WAIT.
REQ-023 cordic_angle SHALL be a register that changes only in ISSUE and stays stable until the next ISSUE.
REQ-024 In WAIT, when cordic_done=1 the block SHALL capture cordic_cos and cordic_sin into sample_cos and sample_sin, set sample_valid=1, and go to HOLD.
REQ-025 In WAIT, if the watchdog reaches TIMEOUT cycles without cordic_done, the block SHALL set timeout_err=1 and go to IDLE with sample_valid left at 0; a cordic_done arriving in the same cycle as the timeout SHALL win.
REQ-026 The phase update SHALL be computed as s = phase_acc + phase_inc in ANGLE_WIDTH+1 bits; if s >= PI then s -= TWO_PI (33'h0C90FDAA2); if s < -PI then s += TWO_PI; the result is truncated to ANGLE_WIDTH bits, keeping phase_acc in [-PI, PI).
REQ-027 In HOLD, the outputs sample_valid, sample_cos and sample_sin SHALL stay stable while sample_ready=0.
REQ-028 In HOLD, on sample_valid & sample_ready the block SHALL clear sample_valid, increment sample_count, and then go to ISSUE if enable=1, else to IDLE; back-to-back throughput is therefore one sample per (CORDIC latency + 2) cycles.
REQ-029 A deassertion of enable SHALL not abort an operation in progress: the current sample completes and is delivered, then the block idles.
REQ-030 cordic_done pulses SHALL be ignored outside WAIT.
REQ-031 phase_load outside IDLE SHALL be ignored.

Reset
REQ-032 On reset=1 at a clock edge the block SHALL enter IDLE with phase_acc=0, cordic_angle=0, cordic_start=0, sample_cos=0, sample_sin=0, sample_valid=0, sample_count=0, timeout_err=0 and the watchdog cleared.
REQ-033 Reset SHALL override all other inputs and SHALL abort mid-operation: a later cordic_done SHALL be ignored.
REQ-034 The constants cordic_x_start and cordic_y_start SHALL be valid during reset.

Verification
REQ-035 A bench SHALL cover the wrap scenario: phase_init=0, phase_inc=32'h3243F6A9, enable=1 -> issued angles 0, 32'h3243F6A9, 32'h9B7812B0 (wrapped from 32'h6487ED52).
REQ-036 A bench SHALL cover the negative wrap scenario: phase_init=32'h9B7812B0, phase_inc=32'hCDBC0957 -> next angle 32'h3243F6A9.
REQ-037 A bench SHALL cover backpressure: sample_ready=0 for 10 cycles after sample_valid -> sample_valid, sample_cos and sample_sin are stable, no cordic_start occurs, sample_count is unchanged; after the ready handshake, sample_count=1.
REQ-038 A bench SHALL cover the timeout scenario: a CORDIC model that never asserts done -> timeout_err=1 exactly TIMEOUT cycles after cordic_start, state returns to IDLE, and sample_valid stays 0.
REQ-039 A bench SHALL cover reset in WAIT: reset asserted during WAIT, then cordic_done asserted -> sample_valid stays 0 and all outputs are at their reset values.
REQ-040 A bench SHALL cover the end-to-end scenario with the 15-iteration CORDIC attached: angle 0 -> sample_cos ~ 16'h4000 +/- 4 LSB and sample_sin ~ 0 +/- 4 LSB.
